// File: rtl/output_signature_compactor.sv
// Compresses a wide output bus into a MISR so the driving logic survives synthesis,
// and reads the signature out MSB-first on one serial pin via a snapshot/shift handshake.
module output_signature_compactor #(
  parameter int                   DATA_WIDTH = 64,
  parameter int                   SIG_WIDTH  = 32,
  parameter logic [SIG_WIDTH-1:0] POLY       = 32'h00400007,
  parameter logic [SIG_WIDTH-1:0] SEED       = {{(SIG_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  sample_en,
  input  logic                  clear,
  output logic [SIG_WIDTH-1:0]  signature,
  output logic [15:0]           sample_count,
  input  logic                  snapshot_req,
  output logic                  sig_bit,
  output logic                  sig_bit_valid,
  output logic                  sig_last,
  output logic                  snap_done,
  output logic                  busy
);

  localparam int NCHUNK = (DATA_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PADW   = NCHUNK * SIG_WIDTH;
  localparam int IDXW   = $clog2(SIG_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  logic [PADW-1:0]      w_data_pad;
  logic [SIG_WIDTH-1:0] w_fold;
  logic [SIG_WIDTH-1:0] w_sig_step;
  logic [SIG_WIDTH-1:0] r_sig;
  logic [15:0]          r_count;

  state_t               r_state, w_state_next;
  logic [SIG_WIDTH-1:0] r_snap, w_snap_next;
  logic [IDXW-1:0]      r_idx, w_idx_next;
  logic                 r_sig_bit, w_sig_bit_next;
  logic                 r_valid, w_valid_next;
  logic                 r_last, w_last_next;
  logic                 r_done, w_done_next;
  logic                 r_busy, w_busy_next;

  // Zero-pad so the last partial chunk folds in cleanly.
  assign w_data_pad = PADW'(data_in);

  always_comb begin
    w_fold = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      w_fold = w_fold ^ w_data_pad[k*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  assign w_sig_step = {r_sig[SIG_WIDTH-2:0], 1'b0}
                    ^ (r_sig[SIG_WIDTH-1] ? POLY : '0)
                    ^ w_fold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sig   <= SEED;
      r_count <= '0;
    end else if (clear) begin
      r_sig   <= SEED;
      r_count <= '0;
    end else if (sample_en) begin
      r_sig <= w_sig_step;
      if (r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_snap_next  = r_snap;
    w_idx_next   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (snapshot_req) begin
          w_snap_next  = r_sig;
          w_idx_next   = IDXW'(SIG_WIDTH - 1);
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_idx == '0) begin
          w_state_next = ST_DONE;
        end else begin
          w_idx_next = r_idx - 1'b1;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave straight from flops.
    w_valid_next   = (w_state_next == ST_SHIFT);
    w_sig_bit_next = w_valid_next & w_snap_next[w_idx_next];
    w_last_next    = w_valid_next && (w_idx_next == '0);
    w_done_next    = (w_state_next == ST_DONE);
    w_busy_next    = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_snap    <= '0;
      r_idx     <= '0;
      r_sig_bit <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_snap    <= w_snap_next;
      r_idx     <= w_idx_next;
      r_sig_bit <= w_sig_bit_next;
      r_valid   <= w_valid_next;
      r_last    <= w_last_next;
      r_done    <= w_done_next;
      r_busy    <= w_busy_next;
    end
  end

  assign signature     = r_sig;
  assign sample_count  = r_count;
  assign sig_bit       = r_sig_bit;
  assign sig_bit_valid = r_valid;
  assign sig_last      = r_last;
  assign snap_done     = r_done;
  assign busy          = r_busy;

endmodule

// File: doc/output_signature_compactor.md
Name: output_signature_compactor

Overview:
- Sink-side counterpart to the random number generator used in our stimulus wrappers.
- Compresses a wide design output bus into a multiple-input signature register (MISR), so Vivado cannot trim the logic that drives those outputs.
- Reads the signature out on a single serial pin using a snapshot/shift handshake, which keeps top-level pin count small.
- Instantiated in the *_random wrappers, one instance per wide output group.

Parameters:
- DATA_WIDTH, 64: width of the compressed output bus.
- SIG_WIDTH, 32: width of the MISR and snapshot register; must be >= 2.
- POLY, 32'h00400007: feedback taps (x^32+x^22+x^2+x+1); the top term is implicit.
- SEED, 1: MISR value after reset or clear; must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- data_in  in  DATA_WIDTH  design outputs to compress
- sample_en  in  1  fold data_in into the MISR this cycle
- clear  in  1  synchronous restart of MISR and counter
- signature  out  SIG_WIDTH  live MISR register
- sample_count  out  16  number of accepted samples, saturating
- snapshot_req  in  1  request serial readout
- sig_bit  out  1  serial signature bit, MSB first
- sig_bit_valid  out  1  sig_bit is meaningful
- sig_last  out  1  high with the final bit
- snap_done  out  1  one-cycle pulse after readout completes
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (asynchronous, active-high) values:
  - signature = SEED; sample_count = 0; snapshot register = 0; bit index = 0.
  - sig_bit = 0, sig_bit_valid = 0, sig_last = 0, snap_done = 0, busy = 0; state = IDLE.
- fold(data_in): XOR of chunks data_in[k*SIG_WIDTH +: SIG_WIDTH]; the final partial chunk is zero-padded.
- MISR update on a clk edge with sample_en=1 and clear=0:
  - sig_next = {sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ fold(data_in).
  - The result is visible on signature the following cycle.
- sample_count:
  - Increments on each accepted sample; saturates at 16'hFFFF.
- clear:
  - Sets signature = SEED and sample_count = 0.
  - Wins over a simultaneous sample_en.
  - Does not affect a readout in progress.
- MISR and counter run independently of the readout FSM and keep accumulating during SHIFT.
- FSM IDLE:
  - busy = 0.
  - On snapshot_req=1: snapshot register <= current signature (value before this edge's update); bit index <= SIG_WIDTH-1; go to SHIFT.
- FSM SHIFT:
  - sig_bit_valid = 1; sig_bit = snapshot[bit index]; busy = 1.
  - sig_last = 1 when bit index = 0; otherwise the index decrements each cycle.
  - After the index-0 cycle, go to DONE.
  - Occupies exactly SIG_WIDTH cycles; the first bit appears the cycle after snapshot_req.
- FSM DONE:
  - snap_done = 1 for one cycle; busy = 1; then return to IDLE.
- snapshot_req in SHIFT or DONE is ignored; there is no queueing.
- snapshot_req held high re-triggers from IDLE, giving back-to-back readouts separated by the DONE cycle.
- Outputs sig_bit, sig_bit_valid, sig_last, snap_done and busy are registered; no combinational path from any input.
- Reset asserted mid-readout aborts immediately to the reset values; the partial readout is discarded.

Test Plan:
- Reset only, no stimulus → signature = 32'h00000001, sample_count = 0, busy = 0, all serial outputs 0.
- sample_en=1 for 1 cycle, data_in=0 → signature = 32'h00000002, sample_count = 1. Same with data_in = 64'h1 → signature = 32'h00000003.
- data_in=0, sample_en=1 for 31 cycles → signature = 32'h80000000. One more sample → signature = 32'h00400007, sample_count = 32.
- data_in = 64'h00000001_00000001, sample_en for 1 cycle → fold = 0, signature = 32'h00000002.
- clear and sample_en both high → signature = SEED, sample_count = 0.
- signature = 32'hA5000001, pulse snapshot_req while sample_en continues:
  - 32 cycles of sig_bit_valid, bits 1,0,1,0,0,1,0,1,...,1 (MSB first).
  - sig_last on cycle 32, snap_done on cycle 33, busy high for cycles 1–33.
  - A second snapshot_req at cycle 10 is ignored.
  - signature keeps changing throughout.
- reset asserted at cycle 12 of SHIFT → all outputs return to reset values immediately; next snapshot_req starts a fresh full readout.
- 70000 samples → sample_count holds 16'hFFFF.
